// File: rtl/sd_det_pkg.sv
// sd_det_pkg: shared states, register addresses and STATUS bit positions for the SD card-detect controller
package sd_det_pkg;
   typedef enum logic [2:0] {
      EMPTY    = 3'd0,
      DB_IN    = 3'd1,
      POWER_UP = 3'd2,
      READY    = 3'd3,
      DB_OUT   = 3'd4
   } state_t;
   localparam logic [1:0] ADDR_STATUS   = 2'd0;
   localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
   localparam logic [1:0] ADDR_EDGE     = 2'd2;
   localparam int STAT_PRESENT   = 0;
   localparam int STAT_WP        = 1;
   localparam int STAT_READY     = 2;
   localparam int STAT_STATE_LSB = 4;
   function automatic logic is_powered(input state_t s);
      return s == POWER_UP || s == READY || s == DB_OUT;
   endfunction
endpackage

// File: rtl/sd_det_sync.sv
// sd_det_sync: 2-flop synchroniser for the raw CD_n/WP socket pins
module sd_det_sync (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] d,
   output logic [1:0] q
);
   logic [1:0] s1_q, s2_q;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end
   assign q = s2_q;
endmodule

// File: rtl/sd_det_ctrl.sv
// sd_det_ctrl: SD socket card-detect debounce, power sequencing and Avalon-MM status/IRQ registers
module sd_det_ctrl
   import sd_det_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int PWRUP_CYCLES    = 50000,
   parameter int CNT_W           = 19
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq,
   input  logic [1:0]  in_port,
   output logic        sd_pwr_en,
   output logic        sd_ready
);
   localparam logic [CNT_W-1:0] DB_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] PU_LOAD = CNT_W'(PWRUP_CYCLES - 1);
   logic [1:0]       pins;
   logic             present, expired, wr, unused;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       edge_q, edge_d, mask_q, mask_d, set_ev, w1c;
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d, pwr_q, pwr_d, rdy_q, rdy_d;
   sd_det_sync u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (in_port),
      .q       (pins)
   );
   assign present = ~pins[0];
   assign expired = cnt_q == '0;
   assign wr      = chipselect && !write_n;
   assign unused  = ^writedata[31:2];
   // A present change is tested before expiry so it wins in the same cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = expired ? cnt_q : cnt_q - 1'b1;
      set_ev  = '0;
      case (state_q)
         EMPTY:
            if (present) begin
               state_d = DB_IN;
               cnt_d   = DB_LOAD;
            end
         DB_IN:
            if (!present) state_d = EMPTY;
            else if (expired) begin
               state_d   = POWER_UP;
               cnt_d     = PU_LOAD;
               set_ev[0] = 1'b1;
            end
         POWER_UP:
            if (!present) begin
               state_d = DB_OUT;
               cnt_d   = DB_LOAD;
            end else if (expired) state_d = READY;
         READY:
            if (!present) begin
               state_d = DB_OUT;
               cnt_d   = DB_LOAD;
            end
         DB_OUT:
            if (present) begin
               state_d = POWER_UP;
               cnt_d   = PU_LOAD;
            end else if (expired) begin
               state_d   = EMPTY;
               set_ev[1] = 1'b1;
            end
         default: state_d = EMPTY;
      endcase
   end
   always_comb begin
      w1c        = (wr && address == ADDR_EDGE) ? writedata[1:0] : 2'b00;
      mask_d     = (wr && address == ADDR_IRQ_MASK) ? writedata[1:0] : mask_q;
      edge_d     = (edge_q & ~w1c) | set_ev;
      irq_d      = |(edge_q & mask_q);
      pwr_d      = is_powered(state_d);
      rdy_d      = state_d == READY;
      readdata_d = '0;
      case (address)
         ADDR_STATUS: begin
            readdata_d[STAT_PRESENT]               = pwr_q;
            readdata_d[STAT_WP]                    = pins[1];
            readdata_d[STAT_READY]                 = rdy_q;
            readdata_d[STAT_STATE_LSB +: 3]        = state_q;
         end
         ADDR_IRQ_MASK: readdata_d[1:0] = mask_q;
         ADDR_EDGE:     readdata_d[1:0] = edge_q;
         default:       readdata_d      = '0;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= EMPTY;
         cnt_q      <= '0;
         edge_q     <= '0;
         mask_q     <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
         pwr_q      <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         edge_q     <= edge_d;
         mask_q     <= mask_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
         pwr_q      <= pwr_d;
         rdy_q      <= rdy_d;
      end
   end
   assign readdata  = readdata_q;
   assign irq       = irq_q;
   assign sd_pwr_en = pwr_q;
   assign sd_ready  = rdy_q;
endmodule

// File: tb/tb_sd_det_ctrl.sv
// tb_sd_det_ctrl: directed and randomised checks of sd_det_ctrl against a run-length based behavioural model
module tb_sd_det_ctrl;
   localparam int D = 8;
   localparam int P = 16;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        irq;
   logic [1:0]  in_port = 2'b01;
   logic        sd_pwr_en, sd_ready;
   int tests = 0;
   int fails = 0;
   bit chk_on = 0;
   always #5 clk = ~clk;
   sd_det_ctrl #(.DEBOUNCE_CYCLES(D), .PWRUP_CYCLES(P), .CNT_W(19)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq),
      .in_port    (in_port),
      .sd_pwr_en  (sd_pwr_en),
      .sd_ready   (sd_ready)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask
   // Model: a level change is accepted after D+1 consecutive equal samples; power-up restarts
   // whenever the card is (re)seen while accepted; ready needs P samples present since then.
   logic [1:0]  s1, s2, w1c;
   logic [1:0]  m_edge, m_mask;
   logic        m_irq, m_pwr, m_rdy;
   logic [2:0]  m_state;
   logic [31:0] m_rd;
   int          run, cyc, t_up;
   bit          last_p, inserted, p, ins_ev, rem_ev;
   always @(posedge clk) begin
      cyc++;
      if (!reset_n) begin
         s1 = '0; s2 = '0; run = 0; last_p = 0; inserted = 0;
         m_edge = '0; m_mask = '0; m_irq = 0; m_pwr = 0; m_rdy = 0; m_state = '0; m_rd = '0;
      end else begin
         case (address)
            2'd0: m_rd = {25'b0, m_state, 1'b0, m_rdy, s2[1], m_pwr};
            2'd1: m_rd = {30'b0, m_mask};
            2'd2: m_rd = {30'b0, m_edge};
            default: m_rd = '0;
         endcase
         m_irq = |(m_edge & m_mask);
         p = ~s2[0];
         s2 = s1;
         s1 = in_port;
         ins_ev = 0;
         rem_ev = 0;
         run = (p == last_p) ? run + 1 : 1;
         last_p = p;
         if (!inserted) begin
            if (p && run == D + 1) begin
               inserted = 1; ins_ev = 1; t_up = cyc;
            end
         end else if (!p && run == D + 1) begin
            inserted = 0; rem_ev = 1;
         end else if (p && run == 1) t_up = cyc;
         m_pwr = inserted;
         m_rdy = inserted && p && (cyc - t_up >= P);
         m_state = !inserted ? (p ? 3'd1 : 3'd0) : (!p ? 3'd4 : (m_rdy ? 3'd3 : 3'd2));
         w1c = (chipselect && !write_n && address == 2'd2) ? writedata[1:0] : 2'b00;
         m_edge = (m_edge & ~w1c) | {rem_ev, ins_ev};
         if (chipselect && !write_n && address == 2'd1) m_mask = writedata[1:0];
      end
   end
   always @(negedge clk) begin
      if (chk_on) begin
         chk("readdata", readdata, m_rd);
         chk("irq", {31'b0, irq}, {31'b0, m_irq});
         chk("sd_pwr_en", {31'b0, sd_pwr_en}, {31'b0, m_pwr});
         chk("sd_ready", {31'b0, sd_ready}, {31'b0, m_rdy});
      end
   end
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick(1);
      chipselect = 1'b0; write_n = 1'b1;
   endtask
   function automatic bit hit(input int sel);
      return sel == 0 ? sd_pwr_en : sel == 1 ? sd_ready : sel == 2 ? !sd_pwr_en : !sd_ready;
   endfunction
   task automatic wait_edges(input string nm, input int sel, input int exp);
      int n;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!hit(sel) && n < 200);
      chk(nm, n, exp);
   endtask
   initial begin
      tick(3);
      chk_on = 1;
      reset_n = 1'b1;
      address = 2'd0;
      tick(1);
      chk("rst_status", readdata, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      chk("rst_pwr", {31'b0, sd_pwr_en}, 32'h0);
      tick(4);
      // insert with interrupts enabled; edges counted from the pin change
      bus_wr(2'd1, 32'h3);
      in_port = 2'b00;
      wait_edges("ins_pwr_delay", 0, D + 3);
      chk("irq_lag", {31'b0, irq}, 32'h0);
      tick(1);
      chk("irq_insert", {31'b0, irq}, 32'h1);
      wait_edges("ins_rdy_delay", 1, P - 1);
      address = 2'd2;
      tick(1);
      chk("edge_insert", readdata, 32'h1);
      address = 2'd0;
      tick(1);
      chk("status_wp0", readdata & 32'h7, 32'h5);
      in_port = 2'b10;
      tick(3);
      chk("status_wp1", readdata & 32'h7, 32'h7);
      in_port = 2'b00;
      tick(2);
      // removal from READY
      bus_wr(2'd2, 32'h1);
      in_port = 2'b01;
      wait_edges("rem_rdy_drop", 3, 3);
      wait_edges("rem_pwr_drop", 2, D);
      address = 2'd2;
      tick(1);
      chk("edge_remove", readdata, 32'h2);
      bus_wr(2'd2, 32'h2);
      address = 2'd2;
      tick(1);
      chk("edge_cleared", readdata, 32'h0);
      chk("irq_cleared", {31'b0, irq}, 32'h0);
      // insert bounce restarts the debounce
      in_port = 2'b00;
      tick(5);
      in_port = 2'b01;
      tick(1);
      in_port = 2'b00;
      wait_edges("bounce_pwr_delay", 0, D + 3);
      // W1C colliding with insert expiry, interrupts masked
      bus_wr(2'd1, 32'h0);
      in_port = 2'b01;
      wait_edges("t5_rem", 2, D + 3);
      bus_wr(2'd2, 32'h3);
      in_port = 2'b00;
      tick(D + 2);
      bus_wr(2'd2, 32'h1);
      chk("t5_pwr", {31'b0, sd_pwr_en}, 32'h1);
      address = 2'd2;
      tick(1);
      chk("t5_set_wins", readdata, 32'h1);
      chk("t5_irq_masked", {31'b0, irq}, 32'h0);
      // short glitch in READY, no removal
      wait_edges("t6_rdy", 1, P - 1);
      bus_wr(2'd2, 32'h3);
      in_port = 2'b01;
      tick(3);
      chk("glitch_pwr_held", {31'b0, sd_pwr_en}, 32'h1);
      chk("glitch_rdy_drop", {31'b0, sd_ready}, 32'h0);
      in_port = 2'b00;
      wait_edges("glitch_rdy_back", 1, P + 3);
      address = 2'd2;
      tick(1);
      chk("glitch_no_event", readdata, 32'h0);
      // reset mid power-up
      in_port = 2'b01;
      tick(3);
      in_port = 2'b00;
      tick(5);
      reset_n = 1'b0;
      tick(1);
      chk("midrst_pwr", {31'b0, sd_pwr_en}, 32'h0);
      chk("midrst_rdy", {31'b0, sd_ready}, 32'h0);
      chk("midrst_irq", {31'b0, irq}, 32'h0);
      chk("midrst_rd", readdata, 32'h0);
      reset_n = 1'b1;
      // randomised levels, bus traffic and occasional resets
      repeat (150) begin
         int hold;
         hold = $urandom_range(1, 2 * D + P);
         in_port = 2'($urandom_range(0, 3));
         repeat (hold) begin
            chipselect = ($urandom_range(0, 3) == 0);
            write_n = 1'($urandom_range(0, 1));
            address = 2'($urandom);
            writedata = $urandom;
            reset_n = ($urandom_range(0, 400) != 0);
            tick(1);
         end
      end
      reset_n = 1'b1;
      chipselect = 1'b0;
      tick(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
